// File: rtl/axis_data_fifo_pkg.sv
// rtl/axis_data_fifo_pkg.sv - shared sizing helpers for the AXI-Stream data FIFO
package axis_data_fifo_pkg;

   // tlast and tuser travel alongside tdata/tkeep in every stored entry
   localparam int C_SIDEBAND_BITS = 2;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

   function automatic int entry_width(input int data_width);
      return data_width + data_width / 8 + C_SIDEBAND_BITS;
   endfunction

endpackage

// File: rtl/axis_fifo_sdp_ram.sv
// rtl/axis_fifo_sdp_ram.sv - simple dual-port storage, synchronous write, asynchronous read
module axis_fifo_sdp_ram
   import axis_data_fifo_pkg::*;
#(
   parameter int G_WIDTH  = 8,
   parameter int G_DEPTH  = 32,
   parameter int G_ADDR_W = clog2(G_DEPTH)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [G_ADDR_W-1:0] waddr_i,
   input  logic [G_WIDTH-1:0]  wdata_i,
   input  logic [G_ADDR_W-1:0] raddr_i,
   output logic [G_WIDTH-1:0]  rdata_o
);

   logic [G_WIDTH-1:0] mem_q [G_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Combinational read lets the head entry fall through the cycle after it is written
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_data_fifo.sv
// rtl/axis_data_fifo.sv - first-word-fall-through AXI-Stream FIFO, one clock, async reset
module axis_data_fifo
   import axis_data_fifo_pkg::*;
#(
   parameter int G_AXIS_DATA_WIDTH = 512,
   parameter int G_FIFO_DEPTH      = 32
) (
   input  logic                           s_axis_aclk,
   input  logic                           s_axis_areset,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic [G_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [G_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                           s_axis_tlast,
   input  logic                           s_axis_tuser,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [G_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [G_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                           m_axis_tlast,
   output logic                           m_axis_tuser
);

   localparam int C_ADDR_W  = clog2(G_FIFO_DEPTH);
   localparam int C_PTR_W   = C_ADDR_W + 1;
   localparam int C_ENTRY_W = entry_width(G_AXIS_DATA_WIDTH);

   logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic                 accept_en_q;
   logic                 full, empty;
   logic                 wr_en, rd_en;
   logic [C_ENTRY_W-1:0] wr_entry, rd_entry;

   // Pointers carry one extra wrap bit: equal means empty, equal except the wrap bit means full
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[C_ADDR_W] != rd_ptr_q[C_ADDR_W]) &&
                  (wr_ptr_q[C_ADDR_W-1:0] == rd_ptr_q[C_ADDR_W-1:0]);

   assign s_axis_tready = accept_en_q & ~full;
   assign m_axis_tvalid = ~empty;

   assign wr_en = s_axis_tvalid & s_axis_tready;
   assign rd_en = m_axis_tvalid & m_axis_tready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
   end

   // accept_en_q holds tready low until the first edge after reset is released
   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         accept_en_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         accept_en_q <= 1'b1;
      end
   end

   assign wr_entry = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   axis_fifo_sdp_ram #(
      .G_WIDTH  (C_ENTRY_W),
      .G_DEPTH  (G_FIFO_DEPTH),
      .G_ADDR_W (C_ADDR_W)
   ) u_ram (
      .clk_i   (s_axis_aclk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q[C_ADDR_W-1:0]),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q[C_ADDR_W-1:0]),
      .rdata_o (rd_entry)
   );

   // Zero the outputs whenever nothing is held, so reset clears them without touching the RAM
   assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} =
      empty ? '0 : rd_entry;

endmodule

// File: tb/tb_axis_data_fifo.sv
// tb/tb_axis_data_fifo.sv - self-checking bench for axis_data_fifo
module tb_axis_data_fifo;

   localparam int DW    = 512;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 32;

   typedef logic [575:0] cw_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic          u;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [KW-1:0] s_axis_tkeep = '0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tuser = 1'b0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tuser;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t q[$];
   bit    model_en = 1'b0;
   int    n_out    = 0;
   beat_t last_out;

   always #5 clk = ~clk;

   axis_data_fifo #(
      .G_AXIS_DATA_WIDTH (DW),
      .G_FIFO_DEPTH      (DEPTH)
   ) dut (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser)
   );

   task automatic chk(input string nm, input cw_t act, input cw_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of beats; ready while not full after reset, valid while non-empty
   always @(negedge clk) begin
      bit exp_rdy, exp_val, do_rd, do_wr;
      beat_t b;
      exp_rdy = !rst && model_en && (q.size() < DEPTH);
      exp_val = !rst && (q.size() > 0);
      chk("s_tready", cw_t'(s_axis_tready), cw_t'(exp_rdy));
      chk("m_tvalid", cw_t'(m_axis_tvalid), cw_t'(exp_val));
      if (rst) begin
         chk("rst_tdata", cw_t'(m_axis_tdata), '0);
         chk("rst_tkeep", cw_t'(m_axis_tkeep), '0);
         chk("rst_tlast_tuser", cw_t'({m_axis_tlast, m_axis_tuser}), '0);
         q.delete();
         model_en = 1'b0;
      end else begin
         if (exp_val) begin
            chk("m_tdata", cw_t'(m_axis_tdata), cw_t'(q[0].d));
            chk("m_tkeep", cw_t'(m_axis_tkeep), cw_t'(q[0].k));
            chk("m_tlast", cw_t'(m_axis_tlast), cw_t'(q[0].l));
            chk("m_tuser", cw_t'(m_axis_tuser), cw_t'(q[0].u));
         end
         do_rd = exp_val && m_axis_tready;
         do_wr = exp_rdy && s_axis_tvalid;
         if (do_rd) begin
            last_out = q.pop_front();
            n_out++;
         end
         if (do_wr) begin
            b.d = s_axis_tdata;
            b.k = s_axis_tkeep;
            b.l = s_axis_tlast;
            b.u = s_axis_tuser;
            q.push_back(b);
         end
         model_en = 1'b1;
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic u);
      bit acc;
      int guard;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 500) begin
         @(negedge clk);
         acc = s_axis_tready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) chk("send_timeout", cw_t'(acc), cw_t'(1));
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input int limit);
      int guard;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < limit) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_empty", cw_t'(q.size()), cw_t'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      logic [DW-1:0] rd_d;
      logic [KW-1:0] rd_k;

      // Reset values and release
      repeat (2) @(posedge clk);
      #1;
      chk("reset_s_tready", cw_t'(s_axis_tready), cw_t'(0));
      chk("reset_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(0));
      chk("reset_m_tdata", cw_t'(m_axis_tdata), cw_t'(0));
      rst = 1'b0;
      #1;
      chk("release_pre_edge_tready", cw_t'(s_axis_tready), cw_t'(0));
      @(posedge clk);
      #1;
      chk("release_first_edge_tready", cw_t'(s_axis_tready), cw_t'(1));

      // Single beat into empty FIFO: visible right after the write edge, not before
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(32'h35);
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b1;
      s_axis_tuser  = 1'b1;
      #1;
      chk("single_pre_edge_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(0));
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      chk("single_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(1));
      chk("single_m_tdata", cw_t'(m_axis_tdata), cw_t'(32'h35));
      chk("single_m_tuser", cw_t'(m_axis_tuser), cw_t'(1));
      drain(20);

      // 64-beat burst with the sink always ready
      start = n_out;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 64; i++) send(DW'(i), '1, (i == 63), 1'b0);
      drain(200);
      chk("burst_count", cw_t'(n_out - start), cw_t'(64));
      chk("burst_last_data", cw_t'(last_out.d), cw_t'(63));
      chk("burst_last_tlast", cw_t'(last_out.l), cw_t'(1));

      // Fill to full with the sink stalled, then drain
      m_axis_tready = 1'b0;
      for (int i = 0; i < 32; i++) send(DW'(100 + i), '1, 1'b0, 1'b0);
      s_axis_tvalid = 1'b0;
      chk("full_s_tready", cw_t'(s_axis_tready), cw_t'(0));
      chk("full_model_size", cw_t'(q.size()), cw_t'(32));
      chk("full_head", cw_t'(m_axis_tdata), cw_t'(100));
      drain(100);
      chk("drained_s_tready", cw_t'(s_axis_tready), cw_t'(1));
      chk("drained_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(0));

      // Full FIFO with write and read offered together: only the read happens
      m_axis_tready = 1'b0;
      for (int i = 0; i < 32; i++) send(DW'(200 + i), '1, 1'b0, 1'b0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(32'hAA);
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      chk("full_rw_occupancy", cw_t'(q.size()), cw_t'(31));
      chk("full_rw_s_tready", cw_t'(s_axis_tready), cw_t'(1));
      chk("full_rw_head", cw_t'(m_axis_tdata), cw_t'(201));
      drain(100);

      // Reset with 10 beats stored
      m_axis_tready = 1'b0;
      for (int i = 0; i < 10; i++) send(DW'(300 + i), '1, 1'b0, 1'b0);
      s_axis_tvalid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(0));
      chk("midrst_s_tready", cw_t'(s_axis_tready), cw_t'(0));
      chk("midrst_m_tdata", cw_t'(m_axis_tdata), cw_t'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("postrst_s_tready", cw_t'(s_axis_tready), cw_t'(1));
      chk("postrst_m_tvalid", cw_t'(m_axis_tvalid), cw_t'(0));

      // Random valid/ready toggling, 1000 beats
      start = n_out;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
               for (int w = 0; w < DW / 32; w++) rd_d[w*32 +: 32] = $urandom();
               rd_k = {$urandom(), $urandom()};
               send(rd_d, rd_k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            s_axis_tvalid = 1'b0;
         end
         begin
            int guard;
            guard = 0;
            while (n_out < start + 1000 && guard < 20000) begin
               m_axis_tready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
               guard++;
            end
            m_axis_tready = 1'b0;
         end
      join
      chk("random_count", cw_t'(n_out - start), cw_t'(1000));
      drain(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_data_fifo.md
AXIS_DATA_FIFO -- requirements
Module: axis_data_fifo

Interface
REQ-001 SHALL have parameter G_AXIS_DATA_WIDTH, default 512, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter G_FIFO_DEPTH, default 32, number of beats stored (power of two, >= 4).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 s_axis_aclk  in  1  sole clock; all ports synchronous to its rising edge.
REQ-005 s_axis_areset  in  1  asynchronous, active-high reset.
REQ-006 s_axis_tvalid  in  1  upstream beat valid.
REQ-007 s_axis_tready  out  1  FIFO can accept a beat.
REQ-008 s_axis_tdata  in  G_AXIS_DATA_WIDTH  upstream data.
REQ-009 s_axis_tkeep  in  G_AXIS_DATA_WIDTH/8  byte enables.
REQ-010 s_axis_tlast  in  1  end of packet.
REQ-011 s_axis_tuser  in  1  sideband, carried unmodified.
REQ-012 m_axis_tvalid  out  1  output beat valid.
REQ-013 m_axis_tready  in  1  downstream accepts beat.
REQ-014 m_axis_tdata / m_axis_tkeep / m_axis_tlast / m_axis_tuser  out  same widths as s_axis side  stored beat fields.

Function
REQ-015 SHALL store tdata, tkeep, tlast, tuser together as one entry per accepted beat, in order, unmodified.
REQ-016 Write SHALL occur on a clock edge where s_axis_tvalid and s_axis_tready are both 1.
REQ-017 Read SHALL occur on a clock edge where m_axis_tvalid and m_axis_tready are both 1.
REQ-018 s_axis_tready SHALL be 1 when occupancy < G_FIFO_DEPTH.
REQ-019 s_axis_tready SHALL be 0 when full, even if a read occurs in the same cycle; no write while full.
REQ-020 Output SHALL be first-word-fall-through: m_axis_tvalid = 1 whenever occupancy > 0, head entry presented on the m_axis fields.
REQ-021 Latency: a beat written at edge N SHALL be visible on m_axis_tvalid/data after edge N (cycle N+1) when the FIFO was empty.
REQ-022 m_axis fields SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Simultaneous write and read when not full and not empty SHALL leave occupancy unchanged.
REQ-024 Simultaneous write and read when empty: only the write takes effect (no read possible).
REQ-025 Read and write pointers SHALL be log2(G_FIFO_DEPTH)+1 bits and wrap modulo 2*G_FIFO_DEPTH; full/empty derived from the extra MSB.
REQ-026 Occupancy SHALL never exceed G_FIFO_DEPTH or underflow below 0.
REQ-027 tlast SHALL be data only; no packet-mode buffering.

Reset
REQ-028 While s_axis_areset=1: pointers 0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0.
REQ-029 s_axis_tready SHALL go to 1 on the first rising edge after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all stored beats immediately (asynchronously).

Structure
REQ-031 Shared package SHALL hold the clog2 function and the entry-width constant (G_AXIS_DATA_WIDTH + G_AXIS_DATA_WIDTH/8 + 2).
REQ-032 Storage SHALL be one sub-module axis_fifo_sdp_ram (simple dual-port, one clock, G_FIFO_DEPTH entries, distributed or block RAM); pointer/flag logic stays in the top module.

Verification
REQ-033 64-beat burst, tdata 0..63, tkeep all ones, tlast on beat 63, m_axis_tready=1 -> 64 beats out in order, tdata 0..63, tlast only on tdata=63, tkeep all ones, tuser 0.
REQ-034 m_axis_tready=0, write 32 beats -> s_axis_tready=0 after 32nd accepted beat; m_axis_tready=1 -> 32 beats drain in order, s_axis_tready returns to 1.
REQ-035 Single beat into empty FIFO -> m_axis_tvalid=1 exactly one cycle after the write edge.
REQ-036 Full FIFO, s_axis_tvalid=1 and m_axis_tready=1 same cycle -> only the read occurs; occupancy 31.
REQ-037 Reset asserted with 10 beats stored -> m_axis_tvalid=0 and s_axis_tready=0 immediately; after release FIFO empty, tready=1 next edge.
REQ-038 Random tvalid/tready toggling, 1000 beats -> output sequence identical to input; m_axis fields stable while stalled.
